// File: rtl/alu_issue_sequencer_pkg.sv
// rtl/alu_issue_sequencer_pkg.sv - shared types and constants for the ALU issue sequencer
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_BOTH = 3'd1,
        SEND_A    = 3'd2,
        WAIT_GAP  = 3'd3,
        SEND_B    = 3'd4,
        HOLD      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        IV_NONE = 2'b00,
        IV_A    = 2'b01,
        IV_B    = 2'b10,
        IV_BOTH = 2'b11
    } inp_valid_e;

    // Commands whose result takes one extra ALU stage in arithmetic mode
    localparam logic [3:0] CMD_INC_MUL = 4'b1001;
    localparam logic [3:0] CMD_SHL_SUB = 4'b1010;

    typedef struct packed {
        logic       split;
        logic [4:0] gap;
        logic       mode;
        logic       cin;
    } req_ctrl_t;

    localparam int REQ_CTRL_W = $bits(req_ctrl_t);

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// rtl/alu_issue_sequencer_if.sv - request handshake bundle into the issue sequencer
interface alu_issue_sequencer_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [DW-1:0] REQ_OPA;
    logic [DW-1:0] REQ_OPB;
    logic [CW-1:0] REQ_CMD;
    logic          REQ_MODE;
    logic          REQ_CIN;
    logic          REQ_SPLIT;
    logic [4:0]    REQ_GAP;

    modport master (
        output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_SPLIT, REQ_GAP,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_SPLIT, REQ_GAP,
        output REQ_READY
    );
endinterface

// File: rtl/alu_issue_sequencer_fifo.sv
// rtl/alu_issue_sequencer_fifo.sv - request FIFO holding whole packed ALU operations
module alu_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; stale entries are unreachable once the pointers clear
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - buffers ALU operations and sequences operand beats and result strobe
module alu_issue_sequencer
    import alu_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int DEPTH   = 4,
    parameter int LAT     = 2,
    parameter int MAX_GAP = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    alu_issue_sequencer_if.slave  req,
    input  logic                  CLR_ERR,
    output logic [1:0]            INP_VALID,
    output logic [DW-1:0]         OPA,
    output logic [DW-1:0]         OPB,
    output logic [CW-1:0]         CMD,
    output logic                  MODE,
    output logic                  CIN,
    output logic                  CE,
    output logic                  RES_STROBE,
    output logic                  BUSY,
    output logic                  GAP_ERR,
    output logic [7:0]            ISSUE_CNT
);
    localparam int FW = REQ_CTRL_W + CW + 2 * DW;

    logic [FW-1:0]          fifo_wdata;
    logic [FW-1:0]          fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;

    req_ctrl_t     head_ctrl;
    logic [CW-1:0] head_cmd;
    logic [DW-1:0] head_opa;
    logic [DW-1:0] head_opb;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hold_len;
    logic       split_q;
    logic [4:0] gap_q;
    inp_valid_e iv_d;
    logic       ce_d;
    logic       strobe_d;
    logic       gap_set;

    assign fifo_wdata = {req.REQ_SPLIT, req.REQ_GAP, req.REQ_MODE, req.REQ_CIN,
                         req.REQ_CMD, req.REQ_OPB, req.REQ_OPA};
    assign {head_ctrl, head_cmd, head_opb, head_opa} = fifo_rdata;

    assign pop           = (state_q == IDLE) && !fifo_empty;
    assign req.REQ_READY = RST_N && !fifo_full;
    assign BUSY          = (state_q != IDLE) || (fifo_count != '0);

    alu_req_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (req.REQ_VALID),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign hold_len = (MODE && (CMD == CW'(CMD_INC_MUL) || CMD == CW'(CMD_SHL_SUB)))
                    ? 8'(LAT + 1) : 8'(LAT);
    assign gap_set  = (state_q == SEND_B) && split_q && (int'(gap_q) >= MAX_GAP);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iv_d     = IV_NONE;
        ce_d     = 1'b0;
        strobe_d = 1'b0;
        case (state_q)
            IDLE:      if (!fifo_empty) state_d = head_ctrl.split ? SEND_A : SEND_BOTH;
            SEND_BOTH: begin state_d = HOLD; cnt_d = hold_len; end
            SEND_A: begin
                if (gap_q == 5'd0) begin
                    state_d = SEND_B;
                end else begin
                    state_d = WAIT_GAP;
                    cnt_d   = {3'b000, gap_q};
                end
            end
            WAIT_GAP:  if (cnt_q == 8'd1) state_d = SEND_B; else cnt_d = cnt_q - 8'd1;
            SEND_B:    begin state_d = HOLD; cnt_d = hold_len; end
            HOLD:      if (cnt_q == 8'd1) state_d = IDLE; else cnt_d = cnt_q - 8'd1;
            default:   state_d = IDLE;
        endcase
        // Outputs are registered, so they are decoded from the state being entered
        case (state_d)
            SEND_BOTH: iv_d = IV_BOTH;
            SEND_A:    iv_d = IV_A;
            SEND_B:    iv_d = IV_B;
            default:   iv_d = IV_NONE;
        endcase
        ce_d     = (state_d != IDLE);
        strobe_d = (state_d == HOLD) && (cnt_d == 8'd1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            split_q    <= 1'b0;
            gap_q      <= '0;
            INP_VALID  <= IV_NONE;
            OPA        <= '0;
            OPB        <= '0;
            CMD        <= '0;
            MODE       <= 1'b0;
            CIN        <= 1'b0;
            CE         <= 1'b0;
            RES_STROBE <= 1'b0;
            GAP_ERR    <= 1'b0;
            ISSUE_CNT  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            INP_VALID  <= iv_d;
            CE         <= ce_d;
            RES_STROBE <= strobe_d;
            ISSUE_CNT  <= ISSUE_CNT + {7'd0, strobe_d};
            GAP_ERR    <= gap_set || (GAP_ERR && !CLR_ERR);
            if (pop) begin
                OPA     <= head_opa;
                OPB     <= head_opb;
                CMD     <= head_cmd;
                MODE    <= head_ctrl.mode;
                CIN     <= head_ctrl.cin;
                split_q <= head_ctrl.split;
                gap_q   <= head_ctrl.gap;
            end
        end
    end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
Operand issue stage placed directly upstream of the ALU datapath. It accepts whole ALU operations over a valid/ready request interface and buffers them in a small FIFO. It drives the ALU's INP_VALID/OPA/OPB/CMD/MODE/CIN/CE inputs, either as a single paired beat or as split A-then-B beats with a programmable gap. After each issue it asserts a result strobe at the cycle the ALU result is due, so a downstream capture stage can sample it.

Parameters:
DW, 8, operand width
CW, 4, command width
DEPTH, 4, request FIFO entries (power of 2)
LAT, 2, cycles from final operand beat to ALU result valid (normal commands)
MAX_GAP, 16, split-operand gap at or above which GAP_ERR is flagged

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accepted when high with REQ_VALID
REQ_OPA  in  DW  operand A
REQ_OPB  in  DW  operand B
REQ_CMD  in  CW  command
REQ_MODE  in  1  1 = arithmetic, 0 = logical
REQ_CIN  in  1  carry in
REQ_SPLIT  in  1  1 = issue A and B in separate beats
REQ_GAP  in  5  idle cycles between A beat and B beat (split only)
CLR_ERR  in  1  clears GAP_ERR
INP_VALID  out  2  to ALU: 01 = A, 10 = B, 11 = both, 00 = none
OPA  out  DW  to ALU
OPB  out  DW  to ALU
CMD  out  CW  to ALU
MODE  out  1  to ALU
CIN  out  1  to ALU
CE  out  1  to ALU clock enable
RES_STROBE  out  1  one-cycle pulse: ALU result valid this cycle
BUSY  out  1  FSM not IDLE or FIFO not empty
GAP_ERR  out  1  sticky: a split issue used gap >= MAX_GAP
ISSUE_CNT  out  8  completed operations, wraps 255 -> 0

Behaviour:
- Reset (RST_N low, async): FIFO empty, FSM = IDLE, all outputs 0, including REQ_READY. An in-flight operation is aborted with no RES_STROBE. FIFO contents are discarded.
- All ALU-side outputs are registered. CMD/MODE/CIN are held stable from the first beat through the end of HOLD.
- FIFO:
  - REQ_READY = !full (registered-free, combinational on count).
  - Push when REQ_VALID && REQ_READY. Pop only in IDLE when not empty.
  - Push and pop in the same cycle are allowed; count is unchanged. When full, no push occurs even if a pop happens that cycle.
- FSM states: IDLE, SEND_BOTH, SEND_A, WAIT_GAP, SEND_B, HOLD.
- IDLE: INP_VALID = 00, CE = 0. If FIFO is not empty, pop into the working register, then go to SEND_A if SPLIT, else SEND_BOTH.
- SEND_BOTH: INP_VALID = 11 with OPA/OPB for 1 cycle, CE = 1, then HOLD.
- SEND_A: INP_VALID = 01 with OPA for 1 cycle. Next state is SEND_B if GAP = 0. Otherwise load gap counter = GAP and go to WAIT_GAP.
- WAIT_GAP: INP_VALID = 00, CE = 1. Decrement the counter; when it reaches 1, next state is SEND_B. Exactly GAP idle cycles separate the A and B beats.
- SEND_B: INP_VALID = 10 with OPB for 1 cycle. If split and GAP >= MAX_GAP, set GAP_ERR. Next state is HOLD.
- HOLD:
  - INP_VALID = 00, CE = 1.
  - Hold count H = LAT+1 when MODE = 1 and CMD is 1001 or 1010 (two-stage multiply/shift-sub); otherwise H = LAT.
  - RES_STROBE pulses on the H-th HOLD cycle. ISSUE_CNT increments that same cycle. Next state is IDLE.
- Result timing: RES_STROBE rises exactly H cycles after the final operand beat (the SEND_BOTH or SEND_B cycle).
- Back-to-back issue: at least one IDLE cycle separates operations, so operation throughput is 1 per (beats + gap + H + 1) cycles.
- GAP_ERR: set-dominant over CLR_ERR in the same cycle. Cleared only by CLR_ERR or reset. The operation is still issued normally.
- ISSUE_CNT wraps modulo 256 with no flag.

Decomposition:
- Shared package alu_pkg: state enum (IDLE..HOLD), INP_VALID encodings (IV_NONE/IV_A/IV_B/IV_BOTH), multi-cycle command constants (CMD_INC_MUL = 4'b1001, CMD_SHL_SUB = 4'b1010), and request struct type.
- One sub-module: alu_req_fifo (parameterised DEPTH, synchronous FIFO with full/empty/count). The FSM and counters live in the top.

Test Plan:
- Reset mid-WAIT_GAP: assert RST_N low during a split request with GAP = 5 -> all outputs 0 immediately, BUSY = 0, no RES_STROBE; after release, REQ_READY = 1.
- Paired issue: OPA = 8'h0F, OPB = 8'h01, CMD = 0000, MODE = 1 -> one cycle INP_VALID = 11, RES_STROBE exactly 2 cycles later, ISSUE_CNT = 1.
- Split issue with GAP = 3, CMD = 0001 -> INP_VALID sequence 01, 00, 00, 00, 10; RES_STROBE 2 cycles after the 10 beat; GAP_ERR stays 0.
- Split issue with GAP = 16 -> GAP_ERR = 1 after SEND_B. CLR_ERR pulse clears it, but if CLR_ERR coincides with a new GAP = 20 SEND_B, GAP_ERR remains 1.
- MODE = 1, CMD = 1001, paired -> RES_STROBE 3 cycles after the 11 beat; the same CMD with MODE = 0 -> 2 cycles.
- FIFO: push 5 requests back-to-back with DEPTH = 4 while the FSM is busy -> REQ_READY drops after 4 entries, 5th accepted after the first pop, all 5 issued in order, ISSUE_CNT = 5.
